// File: rtl/data_memory_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single-ported data memory.
// Define ARB_FIXED_PRIO_EN for fixed P0 priority; round-robin otherwise.
module data_memory_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [DW-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic          owner;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          grant_p1;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    grant_p1 = p1_req & ~p0_req;
  end
`else
  logic last_grant;

  // On a tie the port that did not win last time is served
  always_comb begin
    grant_p1 = (p0_req & p1_req) ? ~last_grant : p1_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant <= 1'b1;
    else if (state == IDLE && (p0_req || p1_req))
      last_grant <= grant_p1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            owner     <= grant_p1;
            cmd_we    <= grant_p1 ? p1_we    : p0_we;
            cmd_addr  <= grant_p1 ? p1_addr  : p0_addr;
            cmd_wdata <= grant_p1 ? p1_wdata : p0_wdata;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (!cmd_we) begin
            if (owner) p1_rdata <= mem_read_data;
            else       p0_rdata <= mem_read_data;
          end
          if (owner) p1_ack <= 1'b1;
          else       p0_ack <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          p0_ack <= 1'b0;
          p1_ack <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are gated by reset too, so a reset mid-access can never commit a write
  assign mem_address    = cmd_addr;
  assign mem_write_data = cmd_wdata;
  assign mem_write      = (state == ACCESS) &  cmd_we & ~reset;
  assign mem_read       = (state == ACCESS) & ~cmd_we & ~reset;

endmodule
